// File: rtl/cpu_txn_pkg.sv
// Shared types and constants for the per-CPU transaction source.
// Word layout, FSM encoding and the gap-LFSR polynomial live here.
package cpu_txn_pkg;

  localparam int DATA_W = 64;
  localparam int SEQ_W  = 32;
  localparam int IDX_W  = 32;
  localparam int LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11 as a Fibonacci tap mask over bits [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [SEQ_W-1:0] seq;
  } txn_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } txn_state_e;

  // An all-zero LFSR would lock up, so that seed is replaced by 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] idx_lo,
                                                  input logic [LFSR_W-1:0] base);
    logic [LFSR_W-1:0] s;
    s = idx_lo ^ base;
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/cpu_txn_lfsr.sv
// 16-bit Fibonacci LFSR, seeded from the CPU index during reset,
// stepping only when adv is high. Low two bits drive the idle gap.
module cpu_txn_lfsr
  import cpu_txn_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] idx_lo,
  input  logic              adv,
  output logic [1:0]        q_lo
);

  logic [LFSR_W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= lfsr_seed(idx_lo, SEED);
    else if (adv) q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  end

  assign q_lo = q[1:0];

endmodule

// File: rtl/cpu_txn_source.sv
// Per-CPU word generator: streams {cpu_index, seq} words over valid/ready,
// optionally with LFSR-driven idle gaps, then holds a sticky done flag.
module cpu_txn_source
  import cpu_txn_pkg::*;
#(
  parameter int unsigned       NUM_TRANSACTIONS = 1000,
  parameter bit                GAP_EN           = 1'b1,
  parameter logic [LFSR_W-1:0] LFSR_SEED        = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  cpu_index,
  input  logic              data_rdy,
  output logic              data_vld,
  output logic [DATA_W-1:0] data,
  output logic              transactions_done
);

  localparam logic [SEQ_W-1:0] LAST_SEQ = SEQ_W'(NUM_TRANSACTIONS - 1);

  txn_state_e state_q, state_d;
  txn_word_t  word_q, word_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] lfsr_lo, gap;
  logic       lfsr_adv;

  cpu_txn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .idx_lo (cpu_index[LFSR_W-1:0]),
    .adv    (lfsr_adv),
    .q_lo   (lfsr_lo)
  );

  assign gap = GAP_EN ? lfsr_lo : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    lfsr_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (NUM_TRANSACTIONS == 0) begin
          state_d = DONE;
        end else begin
          state_d = SEND;
          word_d  = '{idx: cpu_index, seq: '0};
        end
      end
      SEND: begin
        if (data_rdy) begin
          lfsr_adv = 1'b1;
          if (word_q.seq == LAST_SEQ) begin
            state_d = DONE;
          end else begin
            // next word is staged now; during a gap it just waits with vld low
            word_d = '{idx: cpu_index, seq: word_q.seq + 1'b1};
            if (gap == 2'd0) begin
              state_d = SEND;
            end else begin
              state_d = GAP;
              cnt_d   = gap;
            end
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = SEND;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign data_vld          = (state_q == SEND);
  assign transactions_done = (state_q == DONE);
  assign data              = word_q;

endmodule

// File: tb/tb_cpu_txn_source.sv
// Directed bench for cpu_txn_source: several parameterisations side by side,
// each brought out of reset and streamed in turn.
module tb_cpu_txn_source;

  localparam int NI = 8;

  logic            clk = 1'b0;
  logic [NI-1:0]   rst_n, rdy, vld, done;
  logic [63:0]     dat [NI];
  logic [31:0]     idx [NI];
  int              errs = 0;
  int              nchk = 0;

  always #5 clk = ~clk;

  initial begin
    idx[0] = 32'd3;  idx[1] = 32'd5;  idx[2] = 32'd9;  idx[3] = 32'd7;
    idx[4] = 32'd2;  idx[5] = 32'd0;  idx[6] = 32'd1;  idx[7] = 32'h0000ACE1;
  end

  cpu_txn_source #(.NUM_TRANSACTIONS(4),  .GAP_EN(1'b0)) u0 (.clk(clk), .rst_n(rst_n[0]), .cpu_index(idx[0]),
    .data_rdy(rdy[0]), .data_vld(vld[0]), .data(dat[0]), .transactions_done(done[0]));
  cpu_txn_source #(.NUM_TRANSACTIONS(3),  .GAP_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n[1]), .cpu_index(idx[1]),
    .data_rdy(rdy[1]), .data_vld(vld[1]), .data(dat[1]), .transactions_done(done[1]));
  cpu_txn_source #(.NUM_TRANSACTIONS(0),  .GAP_EN(1'b1)) u2 (.clk(clk), .rst_n(rst_n[2]), .cpu_index(idx[2]),
    .data_rdy(rdy[2]), .data_vld(vld[2]), .data(dat[2]), .transactions_done(done[2]));
  cpu_txn_source #(.NUM_TRANSACTIONS(50), .GAP_EN(1'b1)) u3 (.clk(clk), .rst_n(rst_n[3]), .cpu_index(idx[3]),
    .data_rdy(rdy[3]), .data_vld(vld[3]), .data(dat[3]), .transactions_done(done[3]));
  cpu_txn_source #(.NUM_TRANSACTIONS(10), .GAP_EN(1'b1)) u4 (.clk(clk), .rst_n(rst_n[4]), .cpu_index(idx[4]),
    .data_rdy(rdy[4]), .data_vld(vld[4]), .data(dat[4]), .transactions_done(done[4]));
  cpu_txn_source #(.NUM_TRANSACTIONS(8),  .GAP_EN(1'b1)) u5 (.clk(clk), .rst_n(rst_n[5]), .cpu_index(idx[5]),
    .data_rdy(rdy[5]), .data_vld(vld[5]), .data(dat[5]), .transactions_done(done[5]));
  cpu_txn_source #(.NUM_TRANSACTIONS(8),  .GAP_EN(1'b1)) u6 (.clk(clk), .rst_n(rst_n[6]), .cpu_index(idx[6]),
    .data_rdy(rdy[6]), .data_vld(vld[6]), .data(dat[6]), .transactions_done(done[6]));
  cpu_txn_source #(.NUM_TRANSACTIONS(6),  .GAP_EN(1'b1)) u7 (.clk(clk), .rst_n(rst_n[7]), .cpu_index(idx[7]),
    .data_rdy(rdy[7]), .data_vld(vld[7]), .data(dat[7]), .transactions_done(done[7]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: x^16+x^14+x^13+x^11, shifting toward the MSB.
  function automatic logic [15:0] lnext(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Called right after reset release. mode: 0 = rdy high, 1 = 1,0,0 pattern, 2 = random.
  // Returns early after 'stop' transfers when stop > 0.
  task automatic run_stream(input int d, input int n, input bit gen, input int mode,
                            input int stop, output int sig);
    logic [15:0] l;
    logic [63:0] w;
    logic        v, r;
    int          seq, idle, eg, cyc, target;
    l = idx[d][15:0] ^ 16'hACE1;
    if (l == 16'h0) l = 16'h0001;
    seq = 0; idle = 0; eg = 0; cyc = 0; sig = 0;
    target = (stop > 0) ? stop : n;
    chk("idle_vld", {63'd0, vld[d]}, 64'd0);
    while (cyc < 2000 && seq < target) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdy[d] = r;
      v = vld[d];
      w = dat[d];
      step();
      cyc++;
      if (v && r) begin
        chk("word", w, {idx[d], seq[31:0]});
        chk("gap", 64'(idle), 64'(eg));
        sig = sig * 5 + idle;
        eg = gen ? int'(l[1:0]) : 0;
        l = lnext(l);
        seq++;
        idle = vld[d] ? 0 : 1;
        if (seq == n) begin
          chk("done_at_last", {63'd0, done[d]}, 64'd1);
          chk("vld_at_last", {63'd0, vld[d]}, 64'd0);
        end
      end else if (v) begin
        chk("hold_vld", {63'd0, vld[d]}, 64'd1);
        chk("hold_data", dat[d], w);
      end else if (!vld[d]) begin
        idle++;
      end
    end
    chk("transfers", 64'(seq), 64'(target));
  endtask

  int s3, s5, s6, s7;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = '0;
    rdy   = '0;
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      chk("rst_vld", {63'd0, vld[i]}, 64'd0);
      chk("rst_data", dat[i], 64'd0);
      chk("rst_done", {63'd0, done[i]}, 64'd0);
    end

    // back-to-back stream, ready always high
    rdy[0] = 1'b1;
    rst_n[0] = 1'b1;
    chk("t1_idle", {63'd0, vld[0]}, 64'd0);
    step(); chk("t1_v0", {63'd0, vld[0]}, 64'd1); chk("t1_w0", dat[0], 64'h00000003_00000000);
    step(); chk("t1_v1", {63'd0, vld[0]}, 64'd1); chk("t1_w1", dat[0], 64'h00000003_00000001);
    step(); chk("t1_w2", dat[0], 64'h00000003_00000002);
    step(); chk("t1_w3", dat[0], 64'h00000003_00000003); chk("t1_d3", {63'd0, done[0]}, 64'd0);
    step(); chk("t1_vend", {63'd0, vld[0]}, 64'd0); chk("t1_done", {63'd0, done[0]}, 64'd1);
    step(); chk("t1_sticky", {63'd0, done[0]}, 64'd1); chk("t1_vstay", {63'd0, vld[0]}, 64'd0);
    chk("t1_hold_last", dat[0], 64'h00000003_00000003);

    // toggled ready, no gaps
    rst_n[1] = 1'b1;
    run_stream(1, 3, 1'b0, 1, 0, s3);

    // zero-length stream
    rst_n[2] = 1'b1;
    step();
    chk("t3_done", {63'd0, done[2]}, 64'd1);
    chk("t3_vld", {63'd0, vld[2]}, 64'd0);
    repeat (3) begin
      step();
      chk("t3_vld_never", {63'd0, vld[2]}, 64'd0);
    end

    // gapped stream against random ready
    rst_n[3] = 1'b1;
    run_stream(3, 50, 1'b1, 2, 0, s3);
    step();
    chk("t4_sticky", {63'd0, done[3]}, 64'd1);
    chk("t4_last_idx", {32'd0, dat[3][63:32]}, 64'd7);

    // async reset mid-stream, then a full restart
    rst_n[4] = 1'b1;
    run_stream(4, 10, 1'b1, 2, 5, s5);
    #2;
    rst_n[4] = 1'b0;
    #1;
    chk("t5_rst_vld", {63'd0, vld[4]}, 64'd0);
    chk("t5_rst_data", dat[4], 64'd0);
    chk("t5_rst_done", {63'd0, done[4]}, 64'd0);
    step(); step();
    rst_n[4] = 1'b1;
    run_stream(4, 10, 1'b1, 2, 0, s5);

    // two CPUs with different seeds, plus the zero-seed corner
    rst_n[5] = 1'b1;
    run_stream(5, 8, 1'b1, 0, 0, s5);
    rst_n[6] = 1'b1;
    run_stream(6, 8, 1'b1, 0, 0, s6);
    chk("t6_gap_patterns_differ", {63'd0, s5 != s6}, 64'd1);
    chk("t6_idx0", {32'd0, dat[5][63:32]}, 64'd0);
    chk("t6_idx1", {32'd0, dat[6][63:32]}, 64'd1);
    rst_n[7] = 1'b1;
    run_stream(7, 6, 1'b1, 0, 0, s7);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/cpu_txn_source.md
Name: cpu_txn_source

Overview:
- Per-CPU transaction generator. Emits a fixed-length stream of 64-bit data words over a valid/ready handshake, then raises a sticky completion flag.
- Each word carries the CPU's index and a sequence number, so a downstream collector (DPI client/server) can attribute words to their CPU and check ordering.
- Sits below the per-CPU top level, which owns the ready signal and forwards accepted words off-chip.

Parameters:
- NUM_TRANSACTIONS, 1000: number of words emitted before completion (0 allowed).
- GAP_EN, 1: 1 = insert pseudo-random idle cycles between words; 0 = back-to-back words whenever ready.
- LFSR_SEED, 16'hACE1: constant XORed with cpu_index[15:0] to seed the gap LFSR.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_index  input  32  CPU identifier; quasi-static, stable from before reset release.
- data_rdy  input  1  downstream ready.
- data_vld  output  1  word valid.
- data  output  64  payload: [63:32] = cpu_index, [31:0] = sequence number.
- transactions_done  output  1  sticky, high once all words are accepted.

Behaviour:
- Reset: all state clears while rst_n is low, independent of clk.
  - data_vld=0, data=0, transactions_done=0.
  - Sequence counter = 0.
  - LFSR = cpu_index[15:0]^LFSR_SEED; forced to 16'h0001 if that result is 0.
- Handshake: a word transfers on a rising edge where data_vld && data_rdy.
- Hold rule: while data_vld=1 and data_rdy=0, data and data_vld are held unchanged. data_vld never drops without a transfer.
- data_vld is independent of data_rdy; there is no combinational path from data_rdy to any output.
- Start:
  - First edge after reset release with NUM_TRANSACTIONS>0: data_vld=1 and data={cpu_index,32'd0}.
  - So the first word is visible in the 2nd cycle after release.
- After a transfer of sequence number k:
  - k < NUM_TRANSACTIONS-1, gap g = (GAP_EN ? LFSR[1:0] : 0):
    - g=0: data_vld stays 1 and data={cpu_index,k+1} on the same edge (back-to-back).
    - g>0: data_vld=0 for exactly g cycles, then word k+1 is presented.
  - k = NUM_TRANSACTIONS-1: data_vld=0 and transactions_done=1 on that edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per transfer only.
- Idle counter: 2-bit down-counter. data_vld is deasserted while it is nonzero.
- Completion:
  - transactions_done stays 1 until reset.
  - data_vld stays 0 after completion; data holds the last word.
- NUM_TRANSACTIONS=0: transactions_done=1 on the first edge after reset release; data_vld is never asserted.
- Sequence counter is 32 bits. NUM_TRANSACTIONS must be ≤ 2^32-1, so no wrap occurs.
- Reset asserted mid-stream: everything returns to the reset values immediately, and the stream restarts at sequence 0 after release. No partial state survives.
- States:
  - IDLE (post-reset, one cycle) -> SEND
  - SEND (vld=1) -> GAP or SEND on transfer; -> DONE on the last transfer
  - GAP (counting) -> SEND when the counter reaches 0
  - DONE (terminal)

Decomposition:
- Shared package cpu_txn_pkg:
  - DATA_W=64 and SEQ_W=32 constants.
  - Typedef of the data word as a packed struct {idx, seq}.
  - State enum {IDLE, SEND, GAP, DONE}.
  - LFSR tap constant.
- One sub-module is natural: cpu_txn_lfsr (16-bit LFSR with seed load and advance enable).

Test Plan:
- GAP_EN=0, N=4, cpu_index=3, data_rdy held 1 -> words 0x00000003_00000000..0x00000003_00000003 on 4 consecutive cycles; transactions_done=1 the cycle after the last word; data_vld=0 afterwards.
- GAP_EN=0, N=3, data_rdy toggled 1,0,0,1,... (top-level style) -> data held stable through each ready-low period; no word lost or duplicated; sequence 0,1,2 in order.
- N=0 -> transactions_done=1 one cycle after reset release; data_vld never 1.
- GAP_EN=1, N=50, cpu_index=7, random data_rdy:
  - scoreboard sees sequence 0..49 exactly once with [63:32]=7;
  - idle gaps between transfers are ≤3 cycles and match the reference LFSR model.
- Reset asserted asynchronously after the 5th transfer (N=10) -> outputs are 0 immediately; after release the stream restarts at sequence 0 and completes 10 words.
- Two instances with cpu_index=0 and 1, GAP_EN=1 -> different gap patterns; each finishes with its own index in [63:32].
